// File: rtl/axi_mem_arbiter.sv
// Shares one AXI memory-controller port between instruction fetch (I) and data (D).
// States: IDLE | no grant, outputs 0 ; GNT_I | fetch owns port ; GNT_D | data owns port
module axi_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_done,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_load,
  input  logic              d_read,
  input  logic [1:0]        d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_store,
  input  logic              d_done,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_load,
  output logic              m_read,
  output logic [1:0]        m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_store,
  output logic              m_done,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_load
);

  localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          ireq, dreq, force_i;

  assign ireq    = i_read;
  assign dreq    = d_read | (d_write != 2'b00);
  assign force_i = (MAX_D_STREAK != 0) && (streak_q >= STREAK_MAX);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    case (state_q)
      IDLE: begin
        if (dreq && ireq)  state_d = force_i ? GNT_I : GNT_D;
        else if (dreq)     state_d = GNT_D;
        else if (ireq)     state_d = GNT_I;
      end
      GNT_I: begin
        if (m_ready && i_done) begin
          state_d  = IDLE;
          streak_d = '0;
        end
      end
      GNT_D: begin
        if (m_ready && d_done) begin
          state_d = IDLE;
          // Saturating count of D wins that left a fetch waiting
          if (ireq) streak_d = (streak_q >= STREAK_MAX) ? STREAK_MAX : streak_q + 1'b1;
          else      streak_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_read  = 1'b0;
    m_write = 2'b00;
    m_addr  = '0;
    m_store = '0;
    m_done  = 1'b0;
    i_ready = 1'b0;
    i_load  = '0;
    d_ready = 1'b0;
    d_load  = '0;
    case (state_q)
      GNT_I: begin
        m_read  = i_read;
        m_addr  = i_addr;
        m_done  = i_done;
        i_ready = m_ready;
        i_load  = m_load;
      end
      GNT_D: begin
        m_read  = d_read;
        m_write = d_write;
        m_addr  = d_addr;
        m_store = d_store;
        m_done  = d_done;
        d_ready = m_ready;
        d_load  = m_load;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter: instance 0 uses MAX_D_STREAK=4, instance 1 strict D priority.
// A small controller model answers each grant after 3 cycles; a scoreboard checks grant order and data.
module tb_axi_mem_arbiter;

  typedef struct packed {
    logic [7:0]  side;
    logic [31:0] load;
  } exp_t;

  logic        clk;
  logic        nrst;
  logic        i_read   [2];
  logic [31:0] i_addr   [2];
  wire         i_done   [2];
  wire         i_ready  [2];
  wire  [31:0] i_load   [2];
  logic        d_read   [2];
  logic [1:0]  d_write  [2];
  logic [31:0] d_addr   [2];
  logic [31:0] d_store  [2];
  wire         d_done   [2];
  wire         d_ready  [2];
  wire  [31:0] d_load   [2];
  wire         m_read   [2];
  wire  [1:0]  m_write  [2];
  wire  [31:0] m_addr   [2];
  wire  [31:0] m_store  [2];
  wire         m_done   [2];
  logic        m_ready  [2];
  wire  [31:0] m_load   [2];
  logic        auto_i   [2];
  logic        auto_d   [2];
  logic        i_done_m [2];
  logic        d_done_m [2];
  int          rcnt     [2];
  int          n_i      [2];
  int          n_d      [2];

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h100) ? 32'h13 : (a ^ 32'hA5A5_0000);
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign i_done[g] = auto_i[g] ? i_ready[g] : i_done_m[g];
    assign d_done[g] = auto_d[g] ? d_ready[g] : d_done_m[g];
    assign m_load[g] = m_ready[g] ? mem(m_addr[g]) : 32'h0;

    axi_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(g == 0 ? 4 : 0)) u_dut (
      .clk     (clk),
      .nrst    (nrst),
      .i_read  (i_read[g]),
      .i_addr  (i_addr[g]),
      .i_done  (i_done[g]),
      .i_ready (i_ready[g]),
      .i_load  (i_load[g]),
      .d_read  (d_read[g]),
      .d_write (d_write[g]),
      .d_addr  (d_addr[g]),
      .d_store (d_store[g]),
      .d_done  (d_done[g]),
      .d_ready (d_ready[g]),
      .d_load  (d_load[g]),
      .m_read  (m_read[g]),
      .m_write (m_write[g]),
      .m_addr  (m_addr[g]),
      .m_store (m_store[g]),
      .m_done  (m_done[g]),
      .m_ready (m_ready[g]),
      .m_load  (m_load[g])
    );
  end

  // Controller model: ready 3 cycles after a request appears, held until done
  always @(posedge clk or negedge nrst) begin
    for (int k = 0; k < 2; k++) begin
      if (!nrst) begin
        m_ready[k] <= 1'b0;
        rcnt[k]    <= 0;
      end else if (m_ready[k] && m_done[k]) begin
        m_ready[k] <= 1'b0;
        rcnt[k]    <= 0;
      end else if (m_read[k] || (m_write[k] != 2'b00)) begin
        if (rcnt[k] == 2) m_ready[k] <= 1'b1;
        else              rcnt[k]    <= rcnt[k] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Handshake monitor: tallies grants and pops the scoreboard for instance 0
  always @(negedge clk) begin
    if (nrst) begin
      for (int k = 0; k < 2; k++) begin
        if (m_ready[k] && m_done[k]) begin
          logic [7:0]  side;
          logic [31:0] ld;
          if (i_ready[k]) begin
            n_i[k]++;
            side = "I";
            ld   = i_load[k];
          end else begin
            n_d[k]++;
            side = "D";
            ld   = d_load[k];
          end
          if (k == 0 && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("grant_side", {24'h0, side}, {24'h0, e.side});
            check("grant_load", ld, e.load);
          end
        end
      end
    end
  end

  task automatic wait_rdy(input int k, input bit is_d, input string tag);
    int n = 0;
    @(negedge clk);
    while (!(is_d ? d_ready[k] : i_ready[k]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'h0, (is_d ? d_ready[k] : i_ready[k])}, 32'h1);
  endtask

  initial begin
    nrst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_read[k] = 1'b0;  i_addr[k] = 32'h0;  d_read[k] = 1'b0;  d_write[k] = 2'b00;
      d_addr[k] = 32'h0; d_store[k] = 32'h0; auto_i[k] = 1'b1;  auto_d[k] = 1'b1;
      i_done_m[k] = 1'b0; d_done_m[k] = 1'b0; n_i[k] = 0; n_d[k] = 0;
    end
    // Reset with both requests pending
    i_read[0] = 1'b1; i_addr[0] = 32'h100;
    d_read[0] = 1'b1; d_addr[0] = 32'h40;
    repeat (2) @(negedge clk);
    check("rst_m_read",  {31'h0, m_read[0]}, 32'h0);
    check("rst_m_write", {30'h0, m_write[0]}, 32'h0);
    check("rst_m_addr",  m_addr[0], 32'h0);
    check("rst_i_ready", {31'h0, i_ready[0]}, 32'h0);
    check("rst_d_load",  d_load[0], 32'h0);
    nrst = 1'b1;
    exp_q.push_back('{8'h44, mem(32'h40)});
    @(negedge clk);
    check("first_gnt_d_read", {31'h0, m_read[0]}, 32'h1);
    check("first_gnt_d_addr", m_addr[0], 32'h40);
    wait_rdy(0, 1'b1, "first_d_ready");
    check("first_d_i_ready", {31'h0, i_ready[0]}, 32'h0);
    @(posedge clk); #1;
    d_read[0] = 1'b0;

    // Lone fetch once D has released
    exp_q.push_back('{8'h49, 32'h13});
    wait_rdy(0, 1'b0, "fetch_i_ready");
    check("fetch_i_load",  i_load[0], 32'h13);
    check("fetch_d_ready", {31'h0, d_ready[0]}, 32'h0);
    @(posedge clk); #1;
    i_read[0] = 1'b0;
    @(negedge clk);
    check("fetch_idle_m_read", {31'h0, m_read[0]}, 32'h0);
    check("fetch_idle_m_addr", m_addr[0], 32'h0);

    // Lone byte store, released only on ready & done
    d_write[0] = 2'd1; d_addr[0] = 32'h2003; d_store[0] = 32'hAB;
    auto_d[0] = 1'b0; d_done_m[0] = 1'b0;
    exp_q.push_back('{8'h44, mem(32'h2003)});
    @(negedge clk);
    check("store_m_write", {30'h0, m_write[0]}, 32'h1);
    check("store_m_addr",  m_addr[0], 32'h2003);
    check("store_m_store", m_store[0], 32'hAB);
    wait_rdy(0, 1'b1, "store_ready1");
    @(posedge clk); #1;
    auto_i[0] = 1'b0; i_done_m[0] = 1'b1;
    @(negedge clk);
    check("store_held_write2", {30'h0, m_write[0]}, 32'h1);
    check("store_ready2", {31'h0, d_ready[0]}, 32'h1);
    @(posedge clk); #1;
    d_done_m[0] = 1'b1; i_done_m[0] = 1'b0;
    @(negedge clk);
    check("store_held_write3", {30'h0, m_write[0]}, 32'h1);
    check("store_ready3", {31'h0, d_ready[0]}, 32'h1);
    @(posedge clk); #1;
    d_write[0] = 2'd0; d_done_m[0] = 1'b0; auto_d[0] = 1'b1; auto_i[0] = 1'b1;
    @(negedge clk);
    check("store_idle_m_write", {30'h0, m_write[0]}, 32'h0);
    check("store_idle_d_ready", {31'h0, d_ready[0]}, 32'h0);

    // Contention with bounded starvation: D,D,D,D,I
    i_read[0] = 1'b1; i_addr[0] = 32'h300;
    d_read[0] = 1'b1; d_addr[0] = 32'h40;
    for (int j = 0; j < 4; j++) exp_q.push_back('{8'h44, mem(32'h40)});
    exp_q.push_back('{8'h49, mem(32'h300)});
    wait_rdy(0, 1'b0, "streak_i_ready");
    @(posedge clk); #1;
    i_read[0] = 1'b0; d_read[0] = 1'b0;
    @(negedge clk);
    check("streak_cleared", 32'(g_dut[0].u_dut.streak_q), 32'h0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    check("total_d_grants", 32'(n_d[0]), 32'd6);
    check("total_i_grants", 32'(n_i[0]), 32'd2);

    // Strict D priority: I starves while D keeps requesting
    i_read[1] = 1'b1; i_addr[1] = 32'h100;
    d_read[1] = 1'b1; d_addr[1] = 32'h80;
    repeat (80) @(negedge clk);
    check("strict_no_i_grant", 32'(n_i[1]), 32'h0);
    check("strict_d_progress", {31'h0, (n_d[1] > 5)}, 32'h1);
    wait_rdy(1, 1'b1, "strict_d_ready");
    @(posedge clk); #1;
    d_read[1] = 1'b0;
    wait_rdy(1, 1'b0, "strict_i_after_d");
    check("strict_i_load", i_load[1], 32'h13);
    @(posedge clk); #1;
    i_read[1] = 1'b0;
    repeat (2) @(negedge clk);
    check("strict_i_count", 32'(n_i[1]), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_mem_arbiter.md
Name: axi_mem_arbiter

Overview:
- Two-requester arbiter that shares the single AXI memory controller port between instruction fetch (I) and data memory (D).
- Each requester side carries the same signal set as the controller port: read, write, addr, store, done in; ready, load out.
- Sits between the fetch/memory pipeline stages and the AXI controller.
- Grants the port to one requester per transaction and holds the grant until the granted side completes its handshake.
- D has priority by default, with a bounded-starvation counter so fetch always makes progress.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, load/store data width
- MAX_D_STREAK, 4, maximum consecutive D grants while I is pending before I is forced; 0 disables the limit (strict D priority)

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- i_read  in  1  fetch read request
- i_addr  in  ADDR_W  fetch address
- i_done  in  1  fetch stage consumed result
- i_ready  out  1  fetch transaction complete
- i_load  out  DATA_W  fetched word
- d_read  in  1  data read request
- d_write  in  2  0 none, 1 byte, 2 halfword, 3 word
- d_addr  in  ADDR_W  data address
- d_store  in  DATA_W  store data
- d_done  in  1  memory stage consumed result
- d_ready  out  1  data transaction complete
- d_load  out  DATA_W  loaded data
- m_read  out  1  to controller read
- m_write  out  2  to controller write
- m_addr  out  ADDR_W  to controller addr
- m_store  out  DATA_W  to controller store
- m_done  out  1  to controller done
- m_ready  in  1  from controller ready
- m_load  in  DATA_W  from controller load

Behaviour:
- Request definitions: ireq = i_read. dreq = d_read | (d_write != 0). Requesters hold request, addr and store stable until they assert done.
- Async reset (nrst=0): state IDLE, streak counter 0.
- All outputs 0 while in reset and in IDLE.
- States: IDLE, GNT_I, GNT_D. State and counter are registered; output muxing is combinational from the registered state.
- IDLE transitions:
  - dreq only -> GNT_D.
  - ireq only -> GNT_I.
  - Both pending -> GNT_D, unless MAX_D_STREAK != 0 and streak >= MAX_D_STREAK, in which case -> GNT_I.
  - Neither -> stay in IDLE.
  - Arbitration latency: exactly 1 cycle from request to the request appearing on m_*.
- GNT_I:
  - m_read = i_read, m_write = 0, m_addr = i_addr, m_store = 0, m_done = i_done.
  - i_ready = m_ready, i_load = m_load.
  - d_ready = 0, d_load = 0.
- GNT_D:
  - m_read = d_read, m_write = d_write, m_addr = d_addr, m_store = d_store, m_done = d_done.
  - d_ready = m_ready, d_load = m_load.
  - i_ready = 0, i_load = 0.
- Release: in GNT_x, a cycle with m_ready=1 and x_done=1 -> IDLE on the next edge. There is always one IDLE cycle between grants. The grant is never released before that cycle; an in-flight AXI transaction cannot be aborted.
- Streak counter, updated on GNT_D release:
  - If ireq was high during that release cycle: streak = min(streak+1, MAX_D_STREAK).
  - Otherwise: streak = 0.
- On GNT_I release: streak = 0.
- A done from the non-granted side is ignored.
- Protocol violations are undefined: the granted requester dropping its request before ready, or a requester changing addr mid-grant.
- Reset mid-transaction: return to IDLE immediately and drive outputs to 0. The controller is reset by the same nrst.

Test Plan:
- Reset with both requests high -> all outputs 0. First edge after nrst rises: state GNT_D, m_addr = d_addr.
- Lone fetch: i_read=1, i_addr=0x100; controller returns m_ready with m_load=0x00000013 after 3 cycles.
  - i_ready=1 and i_load=0x13 in that cycle; d_ready=0.
  - With i_done=1 in that cycle, m_read=0 on the next cycle (IDLE).
- Lone store: d_write=1, d_addr=0x2003, d_store=0xAB -> m_write=1, m_addr=0x2003, m_store=0xAB. Release only in the cycle with m_ready & d_done.
- Simultaneous I and D requests, MAX_D_STREAK=4, D re-requesting continuously -> grant order D,D,D,D,I. Counter returns to 0 after the I grant.
- MAX_D_STREAK=0, same stimulus -> I is never granted while dreq stays high.
- Ready without done: m_ready=1 for 2 cycles with d_done=0, then d_done=1 -> grant held through all 3 cycles; IDLE on the following cycle. i_done pulses during GNT_D have no effect.
